// File: rtl/mem_responder.sv
// Word-addressed main-memory responder for the 16-bit core's req/ack load/store bus.
// Serves one request at a time, acks after LATENCY wait cycles, flags out-of-range addresses.
module mem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAT_L   = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                latch_en_s;
  logic                enter_resp_s;

  logic                write_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;

  logic                op_write_s;
  logic [ADDR_W-1:0]   op_addr_s;
  logic [DATA_W-1:0]   op_wdata_s;
  logic                in_range_s;
  logic [IDX_W-1:0]    idx_s;
  logic                mem_we_s;

  logic                ack_r;
  logic                err_r;
  logic                busy_r;
  logic [DATA_W-1:0]   rdata_r;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state and counter logic for the IDLE/WAIT/RESP sequence
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    latch_en_s   = 1'b0;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          latch_en_s = 1'b1;
          cnt_s      = LAT_L;
          if (LATENCY == 0) begin
            state_s      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        // <= guards against a corrupted zero count wrapping into a long stall
        if (cnt_r <= 4'd1) begin
          state_s      = RESP;
          enter_resp_s = 1'b1;
          cnt_s        = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // With LATENCY=0 the RESP-entry edge is also the accepting edge, so use the bus values directly
  always_comb begin
    if (state_r == IDLE) begin
      op_write_s = write;
      op_addr_s  = addr;
      op_wdata_s = wdata;
    end else begin
      op_write_s = write_r;
      op_addr_s  = addr_r;
      op_wdata_s = wdata_r;
    end
  end

  assign in_range_s = ({1'b0, op_addr_s} < DEPTH_L);
  assign idx_s      = op_addr_s[IDX_W-1:0];
  assign mem_we_s   = enter_resp_s & in_range_s & op_write_s & ~reset;

  // FSM state and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request capture on the accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      write_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (latch_en_s) begin
      write_r <= write;
      addr_r  <= addr;
      wdata_r <= wdata;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_s] <= op_wdata_s;
    end
  end

  // Registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= '0;
    end else begin
      ack_r  <= enter_resp_s;
      err_r  <= enter_resp_s & ~in_range_s;
      busy_r <= (state_s != IDLE);
      if (enter_resp_s && in_range_s && !op_write_s) begin
        rdata_r <= mem[idx_s];
      end else begin
        rdata_r <= '0;
      end
    end
  end

  assign ack   = ack_r;
  assign err   = err_r;
  assign busy  = busy_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one LATENCY=2 and one LATENCY=0 instance,
// both with DEPTH=256 so the out-of-range path is reachable.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, write;
  logic [15:0] addr, wdata;
  logic        ack, err, busy;
  logic [15:0] rdata;

  logic        req0, write0;
  logic [15:0] addr0, wdata0;
  logic        ack0, err0, busy0;
  logic [15:0] rdata0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .write(write), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .write(write0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on u_dut; bus inputs are scrambled during WAIT to show they are ignored.
  task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic [15:0] rd, output logic e,
                     output logic busy_ok, output logic ack_next);
    @(posedge clk); #1;
    req = 1'b1; write = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; write = ~w; addr = a ^ 16'h0030; wdata = ~d;
    lat = 0; busy_ok = 1'b1;
    @(negedge clk);
    while (!ack && lat < 20) begin
      busy_ok &= busy;
      lat++;
      @(negedge clk);
    end
    busy_ok &= busy;
    rd = rdata;
    e  = err;
    @(negedge clk);
    ack_next = ack;
  endtask

  int          lat;
  logic [15:0] rd;
  logic        e, bok, an;

  initial begin
    reset = 1'b1;
    req = 1'b0; write = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    req0 = 1'b0; write0 = 1'b0; addr0 = 16'h0000; wdata0 = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ack",   {31'd0, ack},   32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_ack0",  {31'd0, ack0},  32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);

    // Write 0x0010 <= 0xBEEF: ack two cycles after the accepting edge, busy throughout
    txn(1'b1, 16'h0010, 16'hBEEF, lat, rd, e, bok, an);
    check("wr_lat",     lat,            32'd2);
    check("wr_busy",    {31'd0, bok},   32'd1);
    check("wr_err",     {31'd0, e},     32'd0);
    check("wr_rdata",   {16'd0, rd},    32'd0);
    check("wr_ack_one", {31'd0, an},    32'd0);
    @(negedge clk);
    check("wr_idle",    {31'd0, busy},  32'd0);

    // Decoy at 0x0020 so a wrongly re-sampled address is visible
    txn(1'b1, 16'h0020, 16'h1111, lat, rd, e, bok, an);
    check("decoy_lat", lat, 32'd2);

    // Read back 0x0010; addr flips to 0x0020 and req drops during WAIT
    txn(1'b0, 16'h0010, 16'h0000, lat, rd, e, bok, an);
    check("rd_lat",   lat,          32'd2);
    check("rd_data",  {16'd0, rd},  32'h0000BEEF);
    check("rd_err",   {31'd0, e},   32'd0);
    check("rd_ack1",  {31'd0, an},  32'd0);
    check("rd_clr",   {16'd0, rdata}, 32'd0);

    // Out of range: preload 0x0000 and 0x00FF, then store to 0x0100 must not alias
    txn(1'b1, 16'h0000, 16'h5A5A, lat, rd, e, bok, an);
    txn(1'b1, 16'h00FF, 16'hC3C3, lat, rd, e, bok, an);
    txn(1'b1, 16'h0100, 16'h1234, lat, rd, e, bok, an);
    check("oor_wr_lat", lat,        32'd2);
    check("oor_wr_err", {31'd0, e}, 32'd1);
    @(negedge clk);
    check("oor_err_clr", {31'd0, err}, 32'd0);
    txn(1'b0, 16'h0100, 16'h0000, lat, rd, e, bok, an);
    check("oor_rd_err",  {31'd0, e},  32'd1);
    check("oor_rd_data", {16'd0, rd}, 32'd0);
    txn(1'b0, 16'h00FF, 16'h0000, lat, rd, e, bok, an);
    check("edge_rd_data", {16'd0, rd}, 32'h0000C3C3);
    check("edge_rd_err",  {31'd0, e},  32'd0);
    txn(1'b0, 16'h0000, 16'h0000, lat, rd, e, bok, an);
    check("alias_rd", {16'd0, rd}, 32'h00005A5A);

    // Reset coinciding with the RESP-entry edge of a write drops it
    txn(1'b1, 16'h0005, 16'h0000, lat, rd, e, bok, an);
    @(posedge clk); #1;
    req = 1'b1; write = 1'b1; addr = 16'h0005; wdata = 16'hAAAA;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_ack",  {31'd0, ack},  32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rstmid_ack2", {31'd0, ack},  32'd0);
    txn(1'b0, 16'h0005, 16'h0000, lat, rd, e, bok, an);
    check("rstmid_rd", {16'd0, rd}, 32'd0);
    txn(1'b0, 16'h0010, 16'h0000, lat, rd, e, bok, an);
    check("keep_rd", {16'd0, rd}, 32'h0000BEEF);

    // LATENCY=0 with req held: write, then reads that ack every second cycle
    @(posedge clk); #1;
    req0 = 1'b1; write0 = 1'b1; addr0 = 16'h0003; wdata0 = 16'h7777;
    @(posedge clk); #1;
    write0 = 1'b0;
    @(negedge clk);
    check("l0_wr_ack", {31'd0, ack0}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("l0_ack%0d", i), {31'd0, ack0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("l0_rd%0d", i), {16'd0, rdata0}, (i % 2 == 1) ? 32'h00007777 : 32'd0);
    end
    req0 = 1'b0;
    @(negedge clk);
    check("l0_stop", {31'd0, ack0}, 32'd0);
    check("l0_err",  {31'd0, err0}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
